// File: rtl/irq_pkg.sv
// irq_pkg
//   Shared types and helpers for the external interrupt controller.
//   irq_state_t : controller state encoding (IDLE, REQ, ACK)
//   irq_idw()   : width of an index able to address nsrc items (minimum 1)
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_t;

    function automatic int irq_idw(input int nsrc);
        return (nsrc <= 1) ? 1 : $clog2(nsrc);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync
//   Parametrised-width two-flop synchroniser, synchronous active-high reset.
//   Ports:
//     clk  in  1  sampling clock
//     rst  in  1  synchronous reset, clears both stages to 0
//     i_d  in  W  asynchronous input
//     o_q  out W  synchronised output (two cycles of latency)
module irq_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
//   External interrupt controller: NSRC active-low lines, per-line level or
//   falling-edge mode, enable masking, fixed lowest-index-first priority and
//   a multi-cycle active-low acknowledge pulse.
//   Optional build macro: IRQ_SYNC_EN adds a 2-flop synchroniser on OINT_n.
//   Ports:
//     clk          in  1     system clock
//     rst          in  1     synchronous active-high reset
//     OINT_n       in  NSRC  interrupt lines, active-low
//     Ei_mie       in  NSRC  per-source enable
//     Ei_globalIE  in  1     global interrupt enable
//     Ei_irqTake   in  1     exception logic takes the presented id
//     Eo_irqValid  out 1     an interrupt is being presented
//     Eo_irqId     out IDW   index of the presented source
//     Eo_mip       out NSRC  pending register
//     IACK_n       out 1     acknowledge to the device, active-low
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | nothing presented; arbitrate eligible pendings
//   REQ   | r_id presented; wait for take or withdraw
//   ACK   | IACK_n held low; down-counter r_cnt runs to terminal count 0
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int              NSRC       = 3,
    parameter int              ACK_CYCLES = 2,
    parameter logic [NSRC-1:0] EDGE_MASK  = '0,
    localparam int             IDW        = irq_idw(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] OINT_n,
    input  logic [NSRC-1:0] Ei_mie,
    input  logic            Ei_globalIE,
    input  logic            Ei_irqTake,
    output logic            Eo_irqValid,
    output logic [IDW-1:0]  Eo_irqId,
    output logic [NSRC-1:0] Eo_mip,
    output logic            IACK_n
);

    localparam int            CW       = irq_idw(ACK_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ACK_CYCLES - 1);

    irq_state_t      r_state;
    logic [IDW-1:0]  r_id;
    logic [CW-1:0]   r_cnt;
    logic [NSRC-1:0] r_pending;
    logic [NSRC-1:0] r_prev;

    logic [NSRC-1:0] w_s;
    logic [NSRC-1:0] w_elig;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [IDW-1:0]  w_win_id;
    logic            w_any;
    logic            w_elig_id;
    logic            w_take;

`ifdef IRQ_SYNC_EN
    irq_sync #(.W(NSRC)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (~OINT_n),
        .o_q (w_s)
    );
`else
    assign w_s = ~OINT_n;
`endif

    assign w_take = (r_state == REQ) && Ei_irqTake;
    assign w_elig = r_pending & Ei_mie & {NSRC{Ei_globalIE}};
    assign w_any  = |w_elig;

    // Edge sources: a new rising sample beats a clear from the take.
    always_comb begin
        w_clr      = '0;
        w_pend_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_clr[i] = w_take && EDGE_MASK[i] && (r_id == IDW'(i));
            if (!EDGE_MASK[i])
                w_pend_nxt[i] = w_s[i];
            else if (w_s[i] && !r_prev[i])
                w_pend_nxt[i] = 1'b1;
            else if (w_clr[i])
                w_pend_nxt[i] = 1'b0;
            else
                w_pend_nxt[i] = r_pending[i];
        end
    end

    // Scan downwards so the lowest eligible index is the last write.
    always_comb begin
        w_win_id  = '0;
        w_elig_id = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_elig[i])
                w_win_id = IDW'(i);
        end
        for (int i = 0; i < NSRC; i++) begin
            if (r_id == IDW'(i))
                w_elig_id = w_elig[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_cnt     <= '0;
            r_pending <= '0;
            r_prev    <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_prev    <= w_s;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_id    <= w_win_id;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (Ei_irqTake) begin
                        r_cnt   <= CNT_LOAD;
                        r_state <= ACK;
                    end else if (!w_elig_id) begin
                        r_state <= IDLE;
                    end
                end
                ACK: begin
                    if (r_cnt == '0)
                        r_state <= IDLE;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Eo_irqValid = (r_state == REQ);
    assign Eo_irqId    = r_id;
    assign Eo_mip      = r_pending;
    assign IACK_n      = (r_state != ACK);

endmodule
